// File: rtl/d_mem_arbiter_if.sv
`default_nettype none
//============================================================================
// Module   : d_mem_arbiter_pkg / d_mem_req_if / d_mem_bus_if
// Brief    : Shared memory-op type plus the requester and memory-side
//            interfaces used by the data-memory arbiter.
// Revision : 1.0 - initial release
//============================================================================

`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 16
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

package d_mem_arbiter_pkg;
  typedef enum logic [1:0] {
    no_mem_op = 2'd0,
    mem_read  = 2'd1,
    mem_write = 2'd2
  } memory_op_t;
endpackage

// Requester side: master is the load/store unit, slave is the arbiter.
interface d_mem_req_if #(
  parameter int ADDR_W = `D_MEMORY_ADDR_WIDTH,
  parameter int DATA_W = `REG_VAL_WIDTH
);
  logic                          req_valid;
  logic                          req_ready;
  d_mem_arbiter_pkg::memory_op_t req_op;
  logic [ADDR_W-1:0]             req_addr;
  logic [DATA_W-1:0]             req_wdata;
  logic                          resp_valid;
  logic [DATA_W-1:0]             resp_rdata;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// Memory side: master is the arbiter, slave is the data memory.
interface d_mem_bus_if #(
  parameter int ADDR_W = `D_MEMORY_ADDR_WIDTH,
  parameter int DATA_W = `REG_VAL_WIDTH
);
  logic                          memory_req_valid;
  d_mem_arbiter_pkg::memory_op_t memory_req_op;
  logic [ADDR_W-1:0]             memory_req_address;
  logic [DATA_W-1:0]             memory_req_data;
  logic                          memory_ready;
  logic                          memory_ack;
  logic [DATA_W-1:0]             memory_data_return;

  modport master (
    output memory_req_valid, memory_req_op, memory_req_address, memory_req_data,
    input  memory_ready, memory_ack, memory_data_return
  );
  modport slave (
    input  memory_req_valid, memory_req_op, memory_req_address, memory_req_data,
    output memory_ready, memory_ack, memory_data_return
  );
endinterface

`default_nettype wire

// File: rtl/d_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module   : d_mem_arbiter
// Brief    : Round-robin arbiter/sequencer between the load port (p0) and
//            the store/commit port (p1) in front of a single-outstanding
//            data memory, with a watchdog on every memory transaction.
// Revision : 1.0 - initial release
//============================================================================

`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 16
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module d_mem_arbiter
  import d_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = `D_MEMORY_ADDR_WIDTH,
  parameter int DATA_W         = `REG_VAL_WIDTH,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_CNT_W       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  wire logic   clk_i,
  input  wire logic   reset_i,        // synchronous, active-low
  d_mem_req_if.slave  p0_if,
  d_mem_req_if.slave  p1_if,
  d_mem_bus_if.master mem_if,
  output logic        busy_o,
  output logic        timeout_err_o
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_CNT_W-1:0] TO_ONE  = TO_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  state_t              state_q;
  logic                rr_last_q;        // port granted most recently
  logic                port_q;           // port owning the current transaction
  memory_op_t          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic [TO_CNT_W-1:0] to_cnt_q;
  logic                mem_req_valid_q;
  logic                p0_resp_valid_q;
  logic                p1_resp_valid_q;
  logic                timeout_err_q;

  logic                grant_valid;
  logic                grant_port;
  logic                accept;
  memory_op_t          sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Round-robin pick: a tie goes to the port that did not win last time.
  always_comb begin
    grant_valid = p0_if.req_valid | p1_if.req_valid;
    if (p0_if.req_valid && p1_if.req_valid) begin
      grant_port = ~rr_last_q;
    end else begin
      grant_port = p1_if.req_valid;
    end
  end

  // A grant only turns into an accept when idle and the memory can take it.
  assign accept    = (state_q == ST_IDLE) && mem_if.memory_ready && grant_valid;
  assign sel_op    = grant_port ? p1_if.req_op    : p0_if.req_op;
  assign sel_addr  = grant_port ? p1_if.req_addr  : p0_if.req_addr;
  assign sel_wdata = grant_port ? p1_if.req_wdata : p0_if.req_wdata;

  assign p0_if.req_ready = accept && !grant_port;
  assign p1_if.req_ready = accept &&  grant_port;

  assign p0_if.resp_valid = p0_resp_valid_q;
  assign p1_if.resp_valid = p1_resp_valid_q;
  assign p0_if.resp_rdata = p0_resp_valid_q ? resp_data_q : '0;
  assign p1_if.resp_rdata = p1_resp_valid_q ? resp_data_q : '0;

  // Latched request fields are held between strobes; only the valid pulses.
  assign mem_if.memory_req_valid   = mem_req_valid_q;
  assign mem_if.memory_req_op      = op_q;
  assign mem_if.memory_req_address = addr_q;
  assign mem_if.memory_req_data    = wdata_q;

  assign busy_o        = (state_q != ST_IDLE);
  assign timeout_err_o = timeout_err_q;

  // Transaction sequencer with registered strobe/response outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q         <= ST_IDLE;
      rr_last_q       <= 1'b1;
      port_q          <= 1'b0;
      op_q            <= no_mem_op;
      addr_q          <= '0;
      wdata_q         <= '0;
      resp_data_q     <= '0;
      to_cnt_q        <= '0;
      mem_req_valid_q <= 1'b0;
      p0_resp_valid_q <= 1'b0;
      p1_resp_valid_q <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      mem_req_valid_q <= 1'b0;
      p0_resp_valid_q <= 1'b0;
      p1_resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q      <= sel_op;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
            port_q    <= grant_port;
            rr_last_q <= grant_port;
            if (sel_op == no_mem_op) begin
              // Nothing to send to memory: complete straight away.
              resp_data_q     <= '0;
              p0_resp_valid_q <= ~grant_port;
              p1_resp_valid_q <= grant_port;
              state_q         <= ST_RESP;
            end else begin
              mem_req_valid_q <= 1'b1;
              state_q         <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          to_cnt_q <= '0;
          state_q  <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (mem_if.memory_ack) begin
            // An ack on the expiry cycle still counts as a good completion.
            resp_data_q     <= (op_q == mem_read) ? mem_if.memory_data_return : '0;
            p0_resp_valid_q <= ~port_q;
            p1_resp_valid_q <= port_q;
            state_q         <= ST_RESP;
          end else if (to_cnt_q == TO_LAST) begin
            resp_data_q     <= '0;
            timeout_err_q   <= 1'b1;
            p0_resp_valid_q <= ~port_q;
            p1_resp_valid_q <= port_q;
            state_q         <= ST_RESP;
          end else begin
            to_cnt_q <= to_cnt_q + TO_ONE;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
